regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Shares the single register-file write port between two writeback requesters:
//   req0 = ALU/main pipeline WB, req1 = multi-cycle unit (mul/div, load return).
//   Arbitrates with a valid/ready handshake, registers the winning address/data, and
//   drives wr_sel, the select of the 5-bit dest-address 2:1 mux and 32-bit data mux.
//   Sits between the WB sources and the register file.
// PARAMETERS
//   AW        5   register address width
//   DW        32  write data width
//   FIXED_PRI 0   0 = round-robin; 1 = req0 always wins when both valid
//   CNT_W     8   width of the saturating conflict counter
// PORTS
//   clk           in   1    system clock, rising edge
//   rst_n         in   1    asynchronous active-low reset
//   stall         in   1    pipeline freeze; blocks new grants
//   req0_valid    in   1    requester 0 has a write pending
//   req0_addr     in   AW   requester 0 destination register
//   req0_data     in   DW   requester 0 write data
//   req0_ready    out  1    requester 0 accepted this cycle (combinational)
//   req1_valid    in   1    requester 1 has a write pending
//   req1_addr     in   AW   requester 1 destination register
//   req1_data     in   DW   requester 1 write data
//   req1_ready    out  1    requester 1 accepted this cycle (combinational)
//   wr_en         out  1    register-file write enable (registered)
//   wr_sel        out  1    mux select: 0 = req0 path, 1 = req1 path (registered)
//   wr_addr       out  AW   registered write address
//   wr_data       out  DW   registered write data
//   conflict_cnt  out  CNT_W  cycles with both valid and stall=0, saturating
// BEHAVIOUR
//   - Reset (async, rst_n=0): wr_en=0, wr_sel=0, wr_addr=0, wr_data=0,
//     conflict_cnt=0, RR pointer -> prefer req0. readys are 0 while rst_n=0.
//   - Grant (comb): stall=1 -> no grant. Only one valid -> that one granted.
//     Both valid -> FIXED_PRI=1: req0; else requester != last granted (ptr).
//   - reqN_ready = grant to N. Accept = valid & ready; max one accept per cycle.
//   - Latency 1: on accept at edge T, at T+1 wr_addr/wr_data = winner's values,
//     wr_sel = winner index, wr_en = 1 unless addr == 0 ($zero: accepted, dropped).
//   - No accept in a cycle -> wr_en=0 next cycle; wr_sel/addr/data hold.
//   - wr_en is a 1-cycle pulse per accepted write; back-to-back accepts give
//     continuous wr_en with alternating wr_sel under contention.
//   - RR pointer updates only on accept (ptr = winner); holds on stall/idle.
//   - stall=1: readys 0; an already-registered write still completes (wr_en
//     pulse not suppressed); conflict_cnt does not increment.
//   - conflict_cnt += 1 per cycle with req0_valid & req1_valid & !stall;
//     saturates at 2^CNT_W-1, never wraps.
//   - Same address from both on consecutive cycles: both written in grant order;
//     the later grant's data is final. No merging or reordering.
//   - Requesters must hold valid/addr/data stable until ready (not checked).
//   - Reset mid-operation: a registered, not-yet-written entry is discarded;
//     wr_en drops immediately (async), not re-issued after reset.
// STRUCTURE
//   - Shared header cpu_defs.vh: REG_AW=5, REG_DW=32, WB_SEL_REQ0=1'b0,
//     WB_SEL_REQ1=1'b1, REG_ZERO=5'd0.
//   - One sub-module: rr_arb2 (2-way grant logic + pointer register, FIXED_PRI
//     param). Output register stage and conflict counter stay in the top.
//   - External 5-bit and 32-bit 2:1 muxes are driven by wr_sel; internal
//     wr_addr/wr_data are the registered selected values for direct use.
// TESTING
//   1 reset: assert rst_n=0 mid-write -> wr_en=0 same cycle; all outputs 0.
//   2 solo: req0 addr=5'd8 data=32'hDEADBEEF -> next cycle wr_en=1 sel=0 addr=8.
//   3 contention RR: both valid 4 cycles -> grants 0,1,0,1; conflict_cnt=4.
//   4 FIXED_PRI=1, both valid 3 cycles -> req0 ready every cycle; req1 never.
//   5 $zero: req1 addr=0 -> req1_ready=1, next cycle wr_en=0, ptr moves to 1.
//   6 stall: accept at T, stall=1 from T -> wr_en pulse at T+1, no new ready.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: address/data widths,
// mux select encodings and the hard-wired zero register.
package regfile_wr_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic WB_SEL_REQ0 = 1'b0;
    localparam logic WB_SEL_REQ1 = 1'b1;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // Round-robin choice under contention: serve whoever was not granted last.
    function automatic logic rr_pick(input logic last_sel);
        return (last_sel == WB_SEL_REQ0) ? WB_SEL_REQ1 : WB_SEL_REQ0;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_arb.sv
// Two-way grant logic with a last-granted pointer; FIXED_PRI=1 makes req0 win
// every contended cycle, otherwise contention alternates.
module rr_arb2
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic v0_i,
    input  logic v1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic ptr_q;
    logic ptr_d;
    logic gnt0;
    logic gnt1;

    // Readys must stay low while reset is held, so reset gates the grant too.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en_i && rst_n) begin
            if (v0_i && v1_i) begin
                if (FIXED_PRI != 0) begin
                    gnt0 = 1'b1;
                end else if (rr_pick(ptr_q) == WB_SEL_REQ0) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = v0_i;
                gnt1 = v1_i;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = WB_SEL_REQ0;
        end else if (gnt1) begin
            ptr_d = WB_SEL_REQ1;
        end
    end

    // Resetting to "req1 was last" makes req0 the first contended winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= WB_SEL_REQ1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the main WB path (req0) and the
// multi-cycle unit (req1); registers the winner and counts contended cycles.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int AW        = REG_AW,
    parameter int DW        = REG_DW,
    parameter int FIXED_PRI = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [DW-1:0]    req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [DW-1:0]    req1_data,
    output logic             req1_ready,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;
    logic             conflict;

    logic             wr_en_q,   wr_en_d;
    logic             wr_sel_q,  wr_sel_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    rr_arb2 #(
        .FIXED_PRI(FIXED_PRI)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!stall),
        .v0_i  (req0_valid),
        .v1_i  (req1_valid),
        .gnt0_o(gnt0),
        .gnt1_o(gnt1)
    );

    // A grant is only ever issued to a valid requester, so grant == accept.
    assign accept   = gnt0 | gnt1;
    assign win_addr = gnt1 ? req1_addr : req0_addr;
    assign win_data = gnt1 ? req1_data : req0_data;
    assign conflict = req0_valid & req1_valid & !stall;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_sel_d  = gnt1 ? WB_SEL_REQ1 : WB_SEL_REQ0;
            wr_addr_d = win_addr;
            wr_data_d = win_data;
            // Writes to $zero are consumed from the requester but never reach the file.
            wr_en_d   = (win_addr != AW'(REG_ZERO));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_sel_q  <= WB_SEL_REQ0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign wr_en        = wr_en_q;
    assign wr_sel       = wr_sel_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [4:0]  a0 = '0;
    logic [4:0]  a1 = '0;
    logic [31:0] d0 = '0;
    logic [31:0] d1 = '0;

    logic [1:0]  o_r0, o_r1, o_en, o_sel;
    logic [4:0]  o_addr0, o_addr1;
    logic [31:0] o_data0, o_data1;
    logic [7:0]  o_cnt0;
    logic [2:0]  o_cnt1;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    logic        m_en[2];
    logic        m_sel[2];
    logic [4:0]  m_addr[2];
    logic [31:0] m_data[2];
    int          m_cnt[2];
    logic        m_last[2];
    int          cnt_max[2];

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.FIXED_PRI(0), .CNT_W(8)) dut_rr (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(o_r0[0]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(o_r1[0]),
        .wr_en(o_en[0]), .wr_sel(o_sel[0]), .wr_addr(o_addr0), .wr_data(o_data0),
        .conflict_cnt(o_cnt0)
    );

    regfile_wr_arbiter #(.FIXED_PRI(1), .CNT_W(3)) dut_fp (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(o_r0[1]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(o_r1[1]),
        .wr_en(o_en[1]), .wr_sel(o_sel[1]), .wr_addr(o_addr1), .wr_data(o_data1),
        .conflict_cnt(o_cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs checked against the model mid-cycle, then the model
    // advances by what the coming rising edge must do.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        g0, g1;
            logic [31:0] act_addr, act_data, act_cnt;
            act_addr = (i == 0) ? 32'(o_addr0) : 32'(o_addr1);
            act_data = (i == 0) ? o_data0 : o_data1;
            act_cnt  = (i == 0) ? 32'(o_cnt0) : 32'(o_cnt1);
            if (!rst_n) begin
                m_en[i] = 1'b0; m_sel[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
                m_cnt[i] = 0; m_last[i] = 1'b1;
            end
            chk($sformatf("wr_en[%0d]", i), 32'(o_en[i]), 32'(m_en[i]));
            chk($sformatf("wr_sel[%0d]", i), 32'(o_sel[i]), 32'(m_sel[i]));
            chk($sformatf("wr_addr[%0d]", i), act_addr, 32'(m_addr[i]));
            chk($sformatf("wr_data[%0d]", i), act_data, m_data[i]);
            chk($sformatf("conflict_cnt[%0d]", i), act_cnt, 32'(m_cnt[i]));
            g0 = 1'b0;
            g1 = 1'b0;
            if (rst_n && !stall) begin
                if (v0 && v1) begin
                    if (i == 1 || m_last[i]) g0 = 1'b1;
                    else g1 = 1'b1;
                end else begin
                    g0 = v0;
                    g1 = v1;
                end
            end
            chk($sformatf("req0_ready[%0d]", i), 32'(o_r0[i]), 32'(g0));
            chk($sformatf("req1_ready[%0d]", i), 32'(o_r1[i]), 32'(g1));
            if (rst_n) begin
                if (v0 && v1 && !stall && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                m_en[i] = 1'b0;
                if (g0 || g1) begin
                    m_sel[i]  = g1;
                    m_addr[i] = g1 ? a1 : a0;
                    m_data[i] = g1 ? d1 : d0;
                    m_en[i]   = (m_addr[i] != 5'd0);
                    m_last[i] = g1;
                end
            end
        end
    end

    task automatic drive(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                         input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
                         input logic ist);
        @(posedge clk);
        #1;
        v0 = iv0; a0 = ia0; d0 = id0;
        v1 = iv1; a1 = ia1; d1 = id1;
        stall = ist;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic r0, r1;
        cnt_max[0] = 255;
        cnt_max[1] = 7;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Solo write from req0.
        drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("solo ready0", 32'(o_r0[0]), 32'd1);
        idle();
        @(negedge clk);
        chk("solo wr_en", 32'(o_en[0]), 32'd1);
        chk("solo wr_sel", 32'(o_sel[0]), 32'd0);
        chk("solo wr_addr", 32'(o_addr0), 32'd8);
        chk("solo wr_data", o_data0, 32'hDEADBEEF);

        // Contention: RR alternates starting with req0, fixed priority never serves req1.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd3, 32'hA0A0_0000 + 32'(k), 1'b1, 5'd4, 32'hB0B0_0000 + 32'(k), 1'b0);
            @(negedge clk);
            chk("rr ready0", 32'(o_r0[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr ready1", 32'(o_r1[0]), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("fp ready0", 32'(o_r0[1]), 32'd1);
            chk("fp ready1", 32'(o_r1[1]), 32'd0);
        end
        idle();
        @(negedge clk);
        chk("rr conflict_cnt", 32'(o_cnt0), 32'd4);
        chk("fp conflict_cnt", 32'(o_cnt1), 32'd4);
        chk("rr last sel", 32'(o_sel[0]), 32'd1);

        // $zero write from req1 is accepted, dropped, and still moves the pointer.
        drive(1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'd0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
        @(negedge clk);
        chk("zero ready1", 32'(o_r1[0]), 32'd1);
        drive(1'b1, 5'd6, 32'h6666, 1'b1, 5'd7, 32'h7777, 1'b0);
        @(negedge clk);
        chk("zero wr_en", 32'(o_en[0]), 32'd0);
        chk("zero wr_sel", 32'(o_sel[0]), 32'd1);
        chk("zero then ready0", 32'(o_r0[0]), 32'd1);
        idle();

        // Stall right after an accept: pending write completes, no new grant.
        drive(1'b1, 5'd9, 32'hC0DE, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hD00D, 1'b1);
        @(negedge clk);
        chk("stall wr_en pulse", 32'(o_en[0]), 32'd1);
        chk("stall wr_addr", 32'(o_addr0), 32'd9);
        chk("stall ready1", 32'(o_r1[0]), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hD00D, 1'b1);
        @(negedge clk);
        chk("stall wr_en drop", 32'(o_en[0]), 32'd0);
        idle();

        // Asynchronous reset while a write is on the port.
        drive(1'b1, 5'd10, 32'hE0E0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre-reset wr_en", 32'(o_en[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset wr_en", 32'(o_en[0]), 32'd0);
        chk("reset wr_addr", 32'(o_addr0), 32'd0);
        chk("reset wr_data", o_data0, 32'd0);
        chk("reset ready0", 32'(o_r0[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = 1'b0;
        @(negedge clk);
        chk("post-reset wr_en", 32'(o_en[0]), 32'd0);

        // Conflict counter saturation.
        drive(1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222, 1'b0);
        repeat (300) @(posedge clk);
        idle();
        @(negedge clk);
        chk("rr cnt saturate", 32'(o_cnt0), 32'd255);
        chk("fp cnt saturate", 32'(o_cnt1), 32'd7);
        do_reset();

        // Random traffic; requesters hold their request until the RR instance accepts it.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r0 = o_r0[0];
            r1 = o_r1[0];
            @(posedge clk);
            #1;
            if (!v0 || r0 || !rst_n) begin
                v0 = 1'($urandom_range(0, 1));
                a0 = 5'($urandom_range(0, 31));
                d0 = $urandom;
            end
            if (!v1 || r1 || !rst_n) begin
                v1 = 1'($urandom_range(0, 1));
                a1 = 5'($urandom_range(0, 31));
                d1 = $urandom;
            end
            stall = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
